common_fifo_reader_skid: RTL
============================

COMMON_FIFO_READER_SKID -- requirements
Module: common_fifo_reader_skid

Interface
REQ-001 The block SHALL have parameter FIFO_WIDTH, default 1, giving the data width in bits of the drained FIFO and of the output stream.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, an asynchronous active-high reset.
REQ-004 The block SHALL have port fifo_dout, input, FIFO_WIDTH, the source FIFO head entry, valid whenever fifo_empty=0.
REQ-005 The block SHALL have port fifo_empty, input, 1, the source FIFO empty flag.
REQ-006 The block SHALL have port fifo_ren, output, 1, the pop request to the source FIFO.
REQ-007 The block SHALL have port dout, output, FIFO_WIDTH, the registered stream data.
REQ-008 The block SHALL have port dout_valid, output, 1, the registered stream valid.
REQ-009 The block SHALL have port dout_ready, input, 1, the consumer ready.
REQ-010 The block SHALL have port flush, input, 1, a synchronous discard of all staged entries.
REQ-011 The block SHALL have port stage_count, output, 2, the number of staged entries (0..2).

Function
REQ-012 The block SHALL hold two FIFO_WIDTH registers, main (M) and skid (S), and a state in {EMPTY, ONE, TWO} encoded equal to stage_count.
REQ-013 The block SHALL drive fifo_ren = ~reset & ~fifo_empty & ~flush & (state != TWO), with no combinational path from dout_ready to fifo_ren.
REQ-014 The block SHALL treat pop = fifo_ren and take = dout_valid & dout_ready.
REQ-015 The block SHALL drive dout = M and dout_valid = (state != EMPTY), both purely from registers.
REQ-016 In EMPTY, the block SHALL load M <= fifo_dout and go to ONE on pop, and hold otherwise.
REQ-017 In ONE, on pop & take the block SHALL load M <= fifo_dout and stay in ONE.
REQ-018 In ONE, on pop & ~take the block SHALL load S <= fifo_dout and go to TWO.
REQ-019 In ONE, on ~pop & take the block SHALL go to EMPTY.
REQ-020 In ONE, on ~pop & ~take the block SHALL hold.
REQ-021 In TWO, the block SHALL never pop; on take it SHALL load M <= S and go to ONE, and otherwise hold.
REQ-022 On flush=1, the block SHALL go to EMPTY on the next edge regardless of state; M and S content is don't-care; a take in the flush cycle counts as a completed transfer; fifo_ren SHALL be 0 in that cycle.
REQ-023 Latency SHALL be one cycle: FIFO non-empty with state EMPTY at edge n gives dout_valid=1 after edge n.
REQ-024 With dout_ready held 1 and the FIFO non-empty, throughput SHALL be one entry per cycle.
REQ-025 Entries SHALL leave in FIFO order, with no loss or duplication except by flush.
REQ-026 stage_count SHALL never exceed 2.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force state=EMPTY, M=0, S=0, dout=0, dout_valid=0, stage_count=0, and fifo_ren=0.
REQ-028 Reset asserted mid-transfer SHALL discard staged entries; FIFO entries not yet popped are unaffected.
REQ-029 After reset is released, the first pop SHALL occur at the first edge with fifo_empty=0.

Verification
REQ-030 The bench SHALL cover: reset asserted with fifo_empty=0 -> fifo_ren=0, dout=0, dout_valid=0 immediately, with no clock required.
REQ-031 The bench SHALL cover: FIFO preloaded with 0x1,0x2,0x3 (FIFO_WIDTH=8), dout_ready=1 -> dout 0x1,0x2,0x3 on three consecutive cycles starting one cycle after the first pop, then dout_valid=0.
REQ-032 The bench SHALL cover: FIFO with 0xA,0xB,0xC, dout_ready=0 -> stage_count reaches 2, fifo_ren=0, 0xC remains in the FIFO; then dout_ready=1 -> outputs 0xA,0xB,0xC in order with no gap.
REQ-033 The bench SHALL cover: state TWO with flush=1 and dout_ready=0 -> stage_count=0 and dout_valid=0 next cycle, fifo_ren=0 during the flush cycle, and the next FIFO entry appears one cycle after flush drops.
REQ-034 The bench SHALL cover: random fifo_empty/dout_ready over 10000 cycles against a scoreboard -> in-order and lossless transfer, stage_count<=2 always, and never fifo_ren=1 while fifo_empty=1.

Source files
------------

// File: rtl/common_fifo_reader_skid.sv
// Drains a show-ahead FIFO into a registered valid/ready stream.
// A two-entry main/skid stage keeps fifo_ren independent of dout_ready.
module common_fifo_reader_skid #(
   parameter int FIFO_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [FIFO_WIDTH-1:0] fifo_dout,
   input  logic                  fifo_empty,
   output logic                  fifo_ren,
   output logic [FIFO_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   input  logic                  flush,
   output logic [1:0]            stage_count
);

   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   logic [1:0]            state;
   logic [FIFO_WIDTH-1:0] main_q;
   logic [FIFO_WIDTH-1:0] skid_q;
   logic                  pop;
   logic                  take;

   // Popping depends only on occupancy, so the consumer's ready never reaches the FIFO
   assign fifo_ren    = ~reset & ~fifo_empty & ~flush & (state != TWO);
   assign pop         = fifo_ren;
   assign take        = dout_valid & dout_ready;
   assign dout        = main_q;
   assign dout_valid  = (state != EMPTY);
   assign stage_count = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (pop) begin
                  main_q <= fifo_dout;
                  state  <= ONE;
               end
            end
            ONE: begin
               if (pop && take) begin
                  main_q <= fifo_dout;
               end else if (pop) begin
                  skid_q <= fifo_dout;
                  state  <= TWO;
               end else if (take) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               // The skid entry is older than anything still in the FIFO
               if (take) begin
                  main_q <= skid_q;
                  state  <= ONE;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule
